// File: rtl/comm_pkg.sv
// Shared definitions for the comm block: command codes, FSM states and register reset values.
package comm_pkg;
    localparam logic [3:0]  CMD_READ_PIN_MAP      = 4'h1;
    localparam logic [3:0]  CMD_READ_ENABLE_MASK  = 4'h2;
    localparam logic [3:0]  CMD_WRITE_ENABLE_MASK = 4'h3;

    localparam logic [31:0] PIN_MAP_RST     = 32'haabbccdd;
    localparam logic [15:0] ENABLE_MASK_RST = 16'haa55;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_DONE,
        ST_ARG_LO,
        ST_ARG_HI
    } comm_state_e;

    function automatic logic [7:0] cmd_byte(input logic [3:0] code);
        return {4'h0, code};
    endfunction
endpackage

// File: rtl/comm_uart_rx.sv
// 8N1 UART receiver sampling mid-bit; ready pulses one cycle per good frame.
module uart_rx #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rx,
    output logic       ready,
    output logic [7:0] data
);
    localparam int CW = $clog2(CLK_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e     state   = RX_IDLE;
    logic [CW-1:0] cnt     = '0;
    logic [2:0]    bit_idx = '0;
    logic [7:0]    shreg   = '0;
    logic [7:0]    data_q  = '0;
    logic          ready_q = 1'b0;
    logic          rx_meta = 1'b1;
    logic          rx_sync = 1'b1;

    assign ready = ready_q;
    assign data  = data_q;

    always_ff @(posedge clk) begin
        rx_meta <= rx;
        rx_sync <= rx_meta;
        ready_q <= 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    state <= RX_START;
                    cnt   <= HALF_LAST;
                end
            end
            RX_START: begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (!rx_sync) begin
                    state   <= RX_DATA;
                    cnt     <= BIT_LAST;
                    bit_idx <= '0;
                end else begin
                    state <= RX_IDLE;   // glitch, not a real start bit
                end
            end
            RX_DATA: begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    shreg   <= {rx_sync, shreg[7:1]};
                    cnt     <= BIT_LAST;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    state <= RX_IDLE;
                    if (rx_sync) begin
                        data_q  <= shreg;
                        ready_q <= 1'b1;
                    end
                end
            end
            default: state <= RX_IDLE;
        endcase
    end
endmodule

// File: rtl/comm_uart_tx.sv
// 8N1 UART transmitter; a held data_ready starts only one frame until it is released.
module uart_tx #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic [7:0] data,
    input  logic       data_ready,
    output logic       done,
    output logic       tx
);
    localparam int CW = $clog2(CLK_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);

    logic          busy      = 1'b0;
    logic          armed     = 1'b1;
    logic          tx_q      = 1'b1;
    logic          done_q    = 1'b0;
    logic [8:0]    frame     = '1;
    logic [3:0]    bits_left = '0;
    logic [CW-1:0] cnt       = '0;

    assign tx   = tx_q;
    assign done = done_q;

    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        if (!data_ready) armed <= 1'b1;
        if (!busy) begin
            if (data_ready && armed) begin
                busy      <= 1'b1;
                armed     <= 1'b0;
                tx_q      <= 1'b0;
                frame     <= {1'b1, data};   // data bits LSB first, then stop
                bits_left <= 4'd9;
                cnt       <= BIT_LAST;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else if (bits_left == 4'd0) begin
            busy   <= 1'b0;
            done_q <= 1'b1;
        end else begin
            tx_q      <= frame[0];
            frame     <= {1'b1, frame[8:1]};
            bits_left <= bits_left - 1'b1;
            cnt       <= BIT_LAST;
        end
    end
endmodule

// File: rtl/comm.sv
// UART command front-end: reads the pin map / enable mask and writes the enable mask.
//  state     | meaning
//  IDLE      | waiting for a command byte
//  LOAD      | present reply byte to uart_tx once it is free
//  WAIT_DONE | reply byte on the wire, waiting for done
//  ARG_LO    | write command, waiting for mask low byte
//  ARG_HI    | write command, waiting for mask high byte
module comm
    import comm_pkg::*;
#(
    parameter int CLK_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        serial_rx,
    output logic        serial_tx,
    output logic [15:0] enabled_out,
    input  tri0         rst
);
    localparam logic [3:0] COMM_READ_PIN_MAP      = CMD_READ_PIN_MAP;
    localparam logic [3:0] COMM_READ_ENABLE_MASK  = CMD_READ_ENABLE_MASK;
    localparam logic [3:0] COMM_WRITE_ENABLE_MASK = CMD_WRITE_ENABLE_MASK;

    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_done;
    logic        tx_data_ready;
    logic [7:0]  tx_data;

    comm_state_e state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        is_pin_q, is_pin_d;
    logic [7:0]  arg_lo_q, arg_lo_d;
    logic        mask_we;
    logic [15:0] enable_mask_q;
    logic [31:0] pin_map_q;
    logic [1:0]  last_byte;

    // Mirrors the transmitter, which keeps running across rst, so a reply
    // never issues a byte into a frame that is still finishing.
    logic        tx_inflight = 1'b0;

    uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clk   (clk),
        .rx    (serial_rx),
        .ready (rx_ready),
        .data  (rx_data)
    );

    uart_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
        .clk        (clk),
        .data       (tx_data),
        .data_ready (tx_data_ready),
        .done       (tx_done),
        .tx         (serial_tx)
    );

    assign enabled_out = enable_mask_q;
    assign last_byte   = is_pin_q ? 2'd3 : 2'd1;

    always_comb begin
        if (is_pin_q) tx_data = pin_map_q[{byte_cnt_q, 3'b000} +: 8];
        else          tx_data = byte_cnt_q[0] ? enable_mask_q[15:8] : enable_mask_q[7:0];
    end

    always_ff @(posedge clk) begin
        if (tx_data_ready)  tx_inflight <= 1'b1;
        else if (tx_done)   tx_inflight <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= '0;
            is_pin_q      <= 1'b0;
            arg_lo_q      <= '0;
            enable_mask_q <= ENABLE_MASK_RST;
            pin_map_q     <= PIN_MAP_RST;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            is_pin_q   <= is_pin_d;
            arg_lo_q   <= arg_lo_d;
            if (mask_we) enable_mask_q <= {rx_data, arg_lo_q};
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        is_pin_d      = is_pin_q;
        arg_lo_d      = arg_lo_q;
        mask_we       = 1'b0;
        tx_data_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                byte_cnt_d = '0;
                if (rx_ready) begin
                    if (rx_data == cmd_byte(COMM_READ_PIN_MAP)) begin
                        is_pin_d = 1'b1;
                        state_d  = ST_LOAD;
                    end else if (rx_data == cmd_byte(COMM_READ_ENABLE_MASK)) begin
                        is_pin_d = 1'b0;
                        state_d  = ST_LOAD;
                    end else if (rx_data == cmd_byte(COMM_WRITE_ENABLE_MASK)) begin
                        state_d = ST_ARG_LO;
                    end
                end
            end
            ST_LOAD: begin
                if (!tx_inflight) begin
                    tx_data_ready = 1'b1;
                    state_d       = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    if (byte_cnt_q == last_byte) begin
                        byte_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_ARG_LO: begin
                if (rx_ready) begin
                    arg_lo_d = rx_data;
                    state_d  = ST_ARG_HI;
                end
            end
            ST_ARG_HI: begin
                if (rx_ready) begin
                    mask_we = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_comm.sv
// Randomized command traffic on serial_rx checked against a register-level model of comm.
module tb_comm;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        serial_rx;
    logic        serial_tx;
    logic [15:0] enabled_out;

    int n_cmp = 0;
    int n_err = 0;
    int frame_err = 0;
    bit x_seen = 1'b0;
    logic [7:0] rx_q[$];

    logic [15:0] model_mask;
    localparam logic [31:0] MODEL_PIN_MAP = 32'haabbccdd;

    always #5 clk = ~clk;

    comm #(.CLK_PER_BIT(CPB)) dut (
        .clk         (clk),
        .serial_rx   (serial_rx),
        .serial_tx   (serial_tx),
        .enabled_out (enabled_out),
        .rst         (rst)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_reply(input string tag, input int n, input logic [31:0] exp);
        int budget;
        logic [31:0] v;
        budget = n * (10 * CPB + 16) + 64;
        v = '0;
        while (rx_q.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        if (rx_q.size() < n) begin
            check({tag, "_timeout"}, rx_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = rx_q.pop_front();
            check(tag, v, exp);
        end
        repeat (12 * CPB) @(posedge clk);
        #1;
        check({tag, "_extra"}, rx_q.size(), 0);
        rx_q.delete();
    endtask

    task automatic do_read(input string tag, input logic [3:0] code);
        send_byte({4'h0, code});
        if (code == 4'h1) expect_reply(tag, 4, MODEL_PIN_MAP);
        else              expect_reply(tag, 2, {16'h0, model_mask});
    endtask

    task automatic do_write(input string tag, input logic [15:0] v);
        send_byte(8'h03);
        send_byte(v[7:0]);
        send_byte(v[15:8]);
        repeat (4) @(posedge clk);
        #1;
        model_mask = v;
        check(tag, enabled_out, model_mask);
    endtask

    task automatic do_unknown(input string tag, input logic [7:0] b);
        send_byte(b);
        repeat (12 * CPB) @(posedge clk);
        #1;
        check(tag, rx_q.size(), 0);
        check({tag, "_mask"}, enabled_out, model_mask);
        rx_q.delete();
    endtask

    // Serial monitor: decodes every frame seen on serial_tx into rx_q.
    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #1;
            if (serial_tx !== 1'b0 && serial_tx !== 1'b1) begin
                x_seen = 1'b1;
            end else if (serial_tx == 1'b0) begin
                repeat (CPB / 2) @(posedge clk);
                #1;
                if (serial_tx !== 1'b0) begin
                    frame_err++;
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(posedge clk);
                        #1;
                        b[i] = serial_tx;
                    end
                    repeat (CPB) @(posedge clk);
                    #1;
                    if (serial_tx !== 1'b1) frame_err++;
                    rx_q.push_back(b);
                end
            end
        end
    end

    initial begin
        int op;
        int budget;
        serial_rx  = 1'b1;
        rst        = 1'b1;
        model_mask = 16'haa55;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mask", enabled_out, 16'haa55);
        check("rst_tx_idle", serial_tx, 1'b1);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        do_read("pin_map_1", 4'h1);
        do_read("pin_map_2", 4'h1);
        do_read("mask_1", 4'h2);
        do_read("mask_2", 4'h2);
        do_write("write_1234", 16'h1234);
        do_read("mask_after_write", 4'h2);
        do_unknown("unknown_7f", 8'h7f);
        do_read("mask_after_unknown", 4'h2);

        // Reset in the middle of a pin-map reply.
        send_byte(8'h01);
        budget = 20 * CPB + 64;
        while (rx_q.size() < 1 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        check("abort_first_byte", rx_q.size(), 1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_mask = 16'haa55;
        check("abort_mask", enabled_out, 16'haa55);
        repeat (14 * CPB) @(posedge clk);
        #1;
        check("abort_dropped", (rx_q.size() <= 2) ? 1 : 0, 1);
        rx_q.delete();
        do_read("pin_map_after_rst", 4'h1);

        for (int k = 0; k < 10; k++) begin
            op = $urandom_range(0, 3);
            case (op)
                0:       do_read("rnd_pin_map", 4'h1);
                1:       do_read("rnd_mask", 4'h2);
                2:       do_write("rnd_write", 16'($urandom));
                default: do_unknown("rnd_unknown", 8'($urandom_range(4, 255)));
            endcase
        end

        check("tx_no_x", x_seen, 1'b0);
        check("tx_framing", frame_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
